uram_port_arbiter: RTL and testbench



---
 rtl/uram_arb_pkg.sv | 41 ++++
 rtl/uram_port_arbiter_if.sv | 29 ++
 rtl/uram_rr_pick2.sv | 68 ++++++
 rtl/uram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_uram_port_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uram_arb_pkg.sv
// Shared widths and types for the URAM port arbiter: command word to the array
// and the tag carried through each port's read-latency pipe.
package uram_arb_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 72;
  localparam int BWE_W  = 9;
  localparam int ID_W   = 3;  // enough for up to 8 requesters

  typedef struct packed {
    logic              en;
    logic              rdb_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [BWE_W-1:0]  bwe;
  } mem_cmd_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } lat_tag_t;

  // An idle port drives an all-zero command; reads never carry byte enables.
  function automatic mem_cmd_t make_cmd(input logic              grant,
                                        input logic              we,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] din,
                                        input logic [BWE_W-1:0]  bwe);
    mem_cmd_t c;
    c = '0;
    if (grant) begin
      c.en     = 1'b1;
      c.rdb_wr = we;
      c.addr   = addr;
      c.din    = din;
      c.bwe    = we ? bwe : '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/uram_port_arbiter_if.sv
// Requester-side bundle of the URAM port arbiter: request handshake plus
// the read-response pulse returned to each requester.
interface uram_port_arbiter_if #(
  parameter int NREQ = 4
);
  // Handshake: a request transfers in any cycle where req_valid[i] and
  // req_ready[i] are both high; the requester holds its fields stable while
  // valid is high and not yet accepted. Responses are a single-cycle
  // rsp_valid[i] pulse with no backpressure.
  logic [NREQ-1:0]                        req_valid;
  logic [NREQ-1:0]                        req_ready;
  logic [NREQ-1:0]                        req_we;
  logic [NREQ*uram_arb_pkg::ADDR_W-1:0]   req_addr;
  logic [NREQ*uram_arb_pkg::DATA_W-1:0]   req_wdata;
  logic [NREQ*uram_arb_pkg::BWE_W-1:0]    req_bwe;
  logic [NREQ-1:0]                        rsp_valid;
  logic [NREQ*uram_arb_pkg::DATA_W-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bwe,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bwe,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/uram_rr_pick2.sv
// Combinational round-robin picker granting up to two requesters per cycle
// (port A then port B), skipping B candidates that collide with A's address.
module uram_rr_pick2
  import uram_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [PTR_W-1:0]       rr_ptr,
  input  logic [NREQ-1:0]        valid,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  output logic [NREQ-1:0]        grant_a,
  output logic [NREQ-1:0]        grant_b,
  output logic                   found_a,
  output logic                   found_b,
  output logic [PTR_W-1:0]       idx_a,
  output logic [PTR_W-1:0]       idx_b,
  output logic [PTR_W-1:0]       next_ptr
);

  always_comb begin
    int               k;
    int               last;
    logic [PTR_W-1:0] kk;
    logic             hazard;
    grant_a  = '0;
    grant_b  = '0;
    found_a  = 1'b0;
    found_b  = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    next_ptr = rr_ptr;
    k        = 0;
    last     = 0;
    kk       = '0;
    hazard   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      kk = PTR_W'(k);
      if (valid[kk]) begin
        if (!found_a) begin
          found_a     = 1'b1;
          idx_a       = kk;
          grant_a[kk] = 1'b1;
        end else if (!found_b) begin
          // Same word on both ports with a write involved would race inside
          // the array; such a candidate waits and the scan moves on.
          hazard = (addr[int'(kk)*ADDR_W +: ADDR_W] == addr[int'(idx_a)*ADDR_W +: ADDR_W])
                   && (we[kk] || we[idx_a]);
          if (!hazard) begin
            found_b     = 1'b1;
            idx_b       = kk;
            grant_b[kk] = 1'b1;
          end
        end
      end
    end
    if (found_a) begin
      last = found_b ? int'(idx_b) : int'(idx_a);
      last = last + 1;
      if (last >= NREQ) last = 0;
      next_ptr = PTR_W'(last);
    end
  end

endmodule

// File: rtl/uram_port_arbiter.sv
// Shares the A/B ports of the banked URAM array among NREQ requesters:
// two-grant round robin, registered command stage, per-port read return.
module uram_port_arbiter
  import uram_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uram_port_arbiter_if.slave       req_if,
  output logic                     mem_en_a,
  output logic                     mem_rdb_wr_a,
  output logic [ADDR_W-1:0]        mem_addr_a,
  output logic [DATA_W-1:0]        mem_din_a,
  output logic [BWE_W-1:0]         mem_bwe_a,
  output logic                     mem_en_b,
  output logic                     mem_rdb_wr_b,
  output logic [ADDR_W-1:0]        mem_addr_b,
  output logic [DATA_W-1:0]        mem_din_b,
  output logic [BWE_W-1:0]         mem_bwe_b,
  input  logic [DATA_W-1:0]        mem_dout_a,
  input  logic [DATA_W-1:0]        mem_dout_b,
  output logic [$clog2(NREQ)-1:0]  dbg_rr_ptr
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] idx_a;
  logic [PTR_W-1:0] idx_b;
  logic [NREQ-1:0]  grant_a;
  logic [NREQ-1:0]  grant_b;
  logic             found_a;
  logic             found_b;

  mem_cmd_t [1:0]            cmd_out;
  logic [1:0]                head_valid;
  logic [1:0][ID_W-1:0]      head_id;
  logic [NREQ-1:0]           hit_a;
  logic [NREQ-1:0]           hit_b;
  logic [NREQ-1:0][DATA_W-1:0] data_q;

  // Masking valid during reset keeps req_ready low and issues nothing.
  uram_rr_pick2 #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .rr_ptr   (rr_ptr),
    .valid    (req_if.req_valid & {NREQ{rst_n}}),
    .we       (req_if.req_we),
    .addr     (req_if.req_addr),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .found_a  (found_a),
    .found_b  (found_b),
    .idx_a    (idx_a),
    .idx_b    (idx_b),
    .next_ptr (next_ptr)
  );

  assign req_if.req_ready = grant_a | grant_b;
  assign dbg_rr_ptr       = rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= next_ptr;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [PTR_W-1:0] idx;
    logic             fnd;
    mem_cmd_t         cmd_d;
    mem_cmd_t         cmd_q;
    logic [ID_W-1:0]  id_q;
    lat_tag_t         pipe_q [MEM_LAT];

    assign idx   = (p == 0) ? idx_a : idx_b;
    assign fnd   = (p == 0) ? found_a : found_b;
    assign cmd_d = make_cmd(fnd, req_if.req_we[idx],
                            req_if.req_addr [int'(idx)*ADDR_W +: ADDR_W],
                            req_if.req_wdata[int'(idx)*DATA_W +: DATA_W],
                            req_if.req_bwe  [int'(idx)*BWE_W  +: BWE_W]);

    // The tag enters the pipe as the command leaves for the array, so the
    // head lines up with the array's DOUT MEM_LAT cycles later.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cmd_q <= '0;
        id_q  <= '0;
        for (int s = 0; s < MEM_LAT; s++) pipe_q[s] <= '0;
      end else begin
        cmd_q     <= cmd_d;
        id_q      <= ID_W'(idx);
        pipe_q[0] <= lat_tag_t'{valid: cmd_q.en & ~cmd_q.rdb_wr, id: id_q};
        for (int s = 1; s < MEM_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end

    assign cmd_out[p]    = cmd_q;
    assign head_valid[p] = pipe_q[MEM_LAT-1].valid;
    assign head_id[p]    = pipe_q[MEM_LAT-1].id;
  end

  assign mem_en_a     = cmd_out[0].en;
  assign mem_rdb_wr_a = cmd_out[0].rdb_wr;
  assign mem_addr_a   = cmd_out[0].addr;
  assign mem_din_a    = cmd_out[0].din;
  assign mem_bwe_a    = cmd_out[0].bwe;
  assign mem_en_b     = cmd_out[1].en;
  assign mem_rdb_wr_b = cmd_out[1].rdb_wr;
  assign mem_addr_b   = cmd_out[1].addr;
  assign mem_din_b    = cmd_out[1].din;
  assign mem_bwe_b    = cmd_out[1].bwe;

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      hit_a[i] = rst_n & head_valid[0] & (head_id[0] == ID_W'(i));
      hit_b[i] = rst_n & head_valid[1] & (head_id[1] == ID_W'(i));
    end
  end

  assign req_if.rsp_valid = hit_a | hit_b;

  // DOUT is only valid in the pulse cycle; keep it for the requester after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (hit_a[i])      data_q[i] <= mem_dout_a;
        else if (hit_b[i]) data_q[i] <= mem_dout_b;
      end
    end
  end

  always_comb begin
    req_if.rsp_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (hit_a[i])      req_if.rsp_data[i*DATA_W +: DATA_W] = mem_dout_a;
      else if (hit_b[i]) req_if.rsp_data[i*DATA_W +: DATA_W] = mem_dout_b;
      else               req_if.rsp_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

endmodule

// File: tb/tb_uram_port_arbiter.sv
// Directed bench for uram_port_arbiter with a two-stage URAM array model
// (input register + synchronous read) behind both ports.
module tb_uram_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 23;
  localparam int DW   = 72;
  localparam int BW   = 9;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  uram_port_arbiter_if #(.NREQ(NREQ)) rif();

  logic          mem_en_a, mem_rdb_wr_a, mem_en_b, mem_rdb_wr_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_din_a, mem_din_b, mem_dout_a, mem_dout_b;
  logic [BW-1:0] mem_bwe_a, mem_bwe_b;
  logic [1:0]    dbg_rr_ptr;

  uram_port_arbiter #(.NREQ(NREQ), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_if(rif),
    .mem_en_a(mem_en_a), .mem_rdb_wr_a(mem_rdb_wr_a), .mem_addr_a(mem_addr_a),
    .mem_din_a(mem_din_a), .mem_bwe_a(mem_bwe_a),
    .mem_en_b(mem_en_b), .mem_rdb_wr_b(mem_rdb_wr_b), .mem_addr_b(mem_addr_b),
    .mem_din_b(mem_din_b), .mem_bwe_b(mem_bwe_b),
    .mem_dout_a(mem_dout_a), .mem_dout_b(mem_dout_b),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  // URAM array model: commands are registered, then executed one edge later.
  typedef struct packed {
    logic en; logic we; logic [AW-1:0] addr; logic [DW-1:0] din; logic [BW-1:0] bwe;
  } ucmd_t;
  ucmd_t s1_a, s1_b;
  logic [DW-1:0] model_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  function automatic void mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [BW-1:0] b);
    logic [DW-1:0] cur;
    cur = mem_read(a);
    for (int j = 0; j < BW; j++) if (b[j]) cur[j*8 +: 8] = d[j*8 +: 8];
    model_mem[a] = cur;
  endfunction

  always @(posedge clk) begin
    s1_a <= '{mem_en_a, mem_rdb_wr_a, mem_addr_a, mem_din_a, mem_bwe_a};
    s1_b <= '{mem_en_b, mem_rdb_wr_b, mem_addr_b, mem_din_b, mem_bwe_b};
    if (s1_a.en) begin
      if (s1_a.we) mem_write(s1_a.addr, s1_a.din, s1_a.bwe);
      else         mem_dout_a <= mem_read(s1_a.addr);
    end
    if (s1_b.en) begin
      if (s1_b.we) mem_write(s1_b.addr, s1_b.din, s1_b.bwe);
      else         mem_dout_b <= mem_read(s1_b.addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    rif.req_valid = '0;
    rif.req_we    = '0;
    rif.req_addr  = '0;
    rif.req_wdata = '0;
    rif.req_bwe   = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    rif.req_valid[i]           = 1'b1;
    rif.req_we[i]              = we;
    rif.req_addr[i*AW +: AW]   = a;
    rif.req_wdata[i*DW +: DW]  = d;
    rif.req_bwe[i*BW +: BW]    = b;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rsp_of(input int i);
    return rif.rsp_data[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rr_data(input int i);
    return 72'h11_1111_1111_1111_1111 * (i + 1);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_reqs();
    rst_n = 1'b0;
    set_req(0, 1'b0, 23'h10, '0, '0);
    step();
    step();
    n_tests++;
    if (rif.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0000", rif.req_ready);
    end
    n_tests++;
    if ({mem_en_a, mem_en_b, mem_addr_a, mem_addr_b} !== '0) begin
      n_fail++; $display("FAIL reset_mem: en_a %b en_b %b addr_a %h addr_b %h expected all 0",
                         mem_en_a, mem_en_b, mem_addr_a, mem_addr_b);
    end
    n_tests++;
    if (rif.rsp_valid !== 4'b0000 || rif.rsp_data !== '0 || dbg_rr_ptr !== 2'd0) begin
      n_fail++; $display("FAIL reset_rsp: rsp_valid %b rsp_data %h rr_ptr %0d expected 0/0/0",
                         rif.rsp_valid, rif.rsp_data, dbg_rr_ptr);
    end
    clear_reqs();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    d = 72'h0DEADBEEF01234567;
    clear_reqs();
    set_req(0, 1'b1, 23'h1005, d, 9'h1FF);
    #1;
    n_tests++;
    if (rif.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL wr_ready: got %b expected 0001", rif.req_ready);
    end
    step();
    clear_reqs();
    set_req(0, 1'b0, 23'h1005, '0, 9'h1FF);
    #1;
    n_tests++;
    if ({mem_en_a, mem_rdb_wr_a, mem_addr_a, mem_din_a, mem_bwe_a, mem_en_b}
        !== {1'b1, 1'b1, 23'h1005, d, 9'h1FF, 1'b0}) begin
      n_fail++; $display("FAIL wr_cmd: en %b wr %b addr %h din %h bwe %h en_b %b expected 1 1 1005 %h 1ff 0",
                         mem_en_a, mem_rdb_wr_a, mem_addr_a, mem_din_a, mem_bwe_a, mem_en_b, d);
    end
    n_tests++;
    if (rif.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rd_ready: got %b expected 0001", rif.req_ready);
    end
    step();
    clear_reqs();
    n_tests++;
    if ({mem_en_a, mem_rdb_wr_a, mem_bwe_a} !== {1'b1, 1'b0, 9'h000}) begin
      n_fail++; $display("FAIL rd_cmd: en %b wr %b bwe %h expected 1 0 000",
                         mem_en_a, mem_rdb_wr_a, mem_bwe_a);
    end
    step();
    n_tests++;
    if (rif.rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rd_early: rsp_valid %b expected 0000", rif.rsp_valid);
    end
    step();
    n_tests++;
    if (rif.rsp_valid !== 4'b0001 || rsp_of(0) !== d) begin
      n_fail++; $display("FAIL rd_rsp: rsp_valid %b data %h expected 0001 %h",
                         rif.rsp_valid, rsp_of(0), d);
    end
    step();
    n_tests++;
    if (rif.rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rd_single_pulse: rsp_valid %b expected 0000", rif.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy, exp_rsp;
    logic [AW-1:0]   exp_aa, exp_ab;
    for (int i = 0; i < NREQ; i++) model_mem[23'h200 + AW'(i)] = rr_data(i);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clear_reqs();
      if (c < 8) for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 23'h200 + AW'(i), '0, '0);
      #1;
      exp_rdy = (c < 8) ? ((c % 2 == 0) ? 4'b0011 : 4'b1100) : 4'b0000;
      exp_rsp = (c >= 3 && c - 3 < 8) ? (((c - 3) % 2 == 0) ? 4'b0011 : 4'b1100) : 4'b0000;
      n_tests++;
      if (rif.req_ready !== exp_rdy || rif.rsp_valid !== exp_rsp) begin
        n_fail++; $display("FAIL rr_cycle%0d: ready %b rsp_valid %b expected %b %b",
                           c, rif.req_ready, rif.rsp_valid, exp_rdy, exp_rsp);
      end
      for (int i = 0; i < NREQ; i++) if (exp_rsp[i]) begin
        n_tests++;
        if (rsp_of(i) !== rr_data(i)) begin
          n_fail++; $display("FAIL rr_data%0d_c%0d: got %h expected %h", i, c, rsp_of(i), rr_data(i));
        end
      end
      if (c >= 1 && c <= 8) begin
        exp_aa = ((c - 1) % 2 == 0) ? 23'h200 : 23'h202;
        exp_ab = exp_aa + 23'h1;
        n_tests++;
        if (mem_addr_a !== exp_aa || mem_addr_b !== exp_ab || !mem_en_a || !mem_en_b) begin
          n_fail++; $display("FAIL rr_cmd_c%0d: addr_a %h addr_b %h en %b%b expected %h %h 11",
                             c, mem_addr_a, mem_addr_b, mem_en_a, mem_en_b, exp_aa, exp_ab);
        end
      end
      step();
    end
  endtask

  task automatic test_hazard();
    logic [DW-1:0] d1, d2, d3, d51;
    d1 = 72'h11_AAAA_0000_1111_2222; d2 = 72'h22_BBBB_3333_4444_5555;
    d3 = 72'h33_CCCC_6666_7777_8888; d51 = 72'h51_5151_5151_5151_5151;
    model_mem[23'h51] = d51;
    do_reset();
    clear_reqs();
    set_req(1, 1'b1, 23'h40, d1, 9'h1FF);
    set_req(2, 1'b1, 23'h40, d2, 9'h1FF);
    #1;
    n_tests++;
    if (rif.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL hz_ready0: got %b expected 0010", rif.req_ready);
    end
    step();
    rif.req_valid[1] = 1'b0;
    #1;
    n_tests++;
    if (mem_en_a !== 1'b1 || mem_din_a !== d1 || mem_en_b !== 1'b0 || rif.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL hz_cycle1: en_a %b din_a %h en_b %b ready %b expected 1 %h 0 0100",
                         mem_en_a, mem_din_a, mem_en_b, rif.req_ready, d1);
    end
    step();
    clear_reqs();
    set_req(3, 1'b0, 23'h40, '0, '0);
    #1;
    n_tests++;
    if (mem_din_a !== d2 || rif.req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL hz_cycle2: din_a %h ready %b expected %h 1000", mem_din_a, rif.req_ready, d2);
    end
    step();
    clear_reqs();
    set_req(1, 1'b1, 23'h50, d3, 9'h1FF);
    set_req(2, 1'b0, 23'h50, '0, '0);
    set_req(3, 1'b0, 23'h51, '0, '0);
    #1;
    n_tests++;
    if (rif.req_ready !== 4'b1010) begin
      n_fail++; $display("FAIL hz_third: ready %b expected 1010", rif.req_ready);
    end
    step();
    clear_reqs();
    set_req(2, 1'b0, 23'h50, '0, '0);
    #1;
    n_tests++;
    if (mem_addr_a !== 23'h50 || mem_addr_b !== 23'h51 || mem_en_b !== 1'b1 || rif.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL hz_cycle4: addr_a %h addr_b %h en_b %b ready %b expected 50 51 1 0100",
                         mem_addr_a, mem_addr_b, mem_en_b, rif.req_ready);
    end
    step();
    clear_reqs();
    #1;
    n_tests++;
    if (rif.rsp_valid !== 4'b1000 || rsp_of(3) !== d2) begin
      n_fail++; $display("FAIL hz_rd_new: rsp_valid %b data %h expected 1000 %h", rif.rsp_valid, rsp_of(3), d2);
    end
    step();
    n_tests++;
    if (rif.rsp_valid !== 4'b1000 || rsp_of(3) !== d51) begin
      n_fail++; $display("FAIL hz_rd_b: rsp_valid %b data %h expected 1000 %h", rif.rsp_valid, rsp_of(3), d51);
    end
    step();
    n_tests++;
    if (rif.rsp_valid !== 4'b0100 || rsp_of(2) !== d3) begin
      n_fail++; $display("FAIL hz_rd_after_wr: rsp_valid %b data %h expected 0100 %h", rif.rsp_valid, rsp_of(2), d3);
    end
    step();
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] exp_d;
    exp_d = 72'hFF_FFFF_FFFF_FFFF_FF00;
    clear_reqs();
    set_req(0, 1'b1, 23'h300, {DW{1'b1}}, 9'h1FF);
    #1;
    n_tests++;
    if (rif.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL be_ready: got %b expected 0001", rif.req_ready);
    end
    step();
    clear_reqs();
    set_req(0, 1'b1, 23'h300, '0, 9'h001);
    step();
    clear_reqs();
    set_req(0, 1'b0, 23'h300, '0, '0);
    #1;
    n_tests++;
    if (mem_bwe_a !== 9'h001 || mem_rdb_wr_a !== 1'b1) begin
      n_fail++; $display("FAIL be_cmd: bwe %h wr %b expected 001 1", mem_bwe_a, mem_rdb_wr_a);
    end
    step();
    clear_reqs();
    step();
    step();
    n_tests++;
    if (rif.rsp_valid !== 4'b0001 || rsp_of(0) !== exp_d) begin
      n_fail++; $display("FAIL be_rsp: rsp_valid %b data %h expected 0001 %h", rif.rsp_valid, rsp_of(0), exp_d);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(0, 1'b0, 23'h1005, '0, '0);
    set_req(1, 1'b0, 23'h203, '0, '0);
    #1;
    n_tests++;
    if (rif.req_ready !== 4'b0011) begin
      n_fail++; $display("FAIL mf_ready: got %b expected 0011", rif.req_ready);
    end
    step();
    clear_reqs();
    set_req(2, 1'b0, 23'h10, '0, '0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rif.req_ready !== 4'b0000 || rif.rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL mf_in_reset: ready %b rsp_valid %b expected 0000 0000", rif.req_ready, rif.rsp_valid);
    end
    step();
    rst_n = 1'b1;
    clear_reqs();
    #1;
    n_tests++;
    if ({mem_en_a, mem_rdb_wr_a, mem_addr_a, mem_din_a, mem_bwe_a,
         mem_en_b, mem_rdb_wr_b, mem_addr_b, mem_din_b, mem_bwe_b} !== '0
        || dbg_rr_ptr !== 2'd0 || rif.rsp_data !== '0) begin
      n_fail++; $display("FAIL mf_cleared: en %b%b addr %h %h rr_ptr %0d rsp_data %h expected all 0",
                         mem_en_a, mem_en_b, mem_addr_a, mem_addr_b, dbg_rr_ptr, rif.rsp_data);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (rif.rsp_valid !== 4'b0000 || mem_en_a !== 1'b0 || mem_en_b !== 1'b0) begin
        n_fail++; $display("FAIL mf_after%0d: rsp_valid %b en %b%b expected 0000 00",
                           c, rif.rsp_valid, mem_en_a, mem_en_b);
      end
    end
  endtask

  task automatic test_no_starve();
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_reqs();
      set_req(0, 1'b0, 23'h1005, '0, '0);
      if (c == 0) set_req(3, 1'b0, 23'h203, '0, '0);
      #1;
      exp_rdy = (c == 0) ? 4'b1001 : 4'b0001;
      n_tests++;
      if (rif.req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL ns_ready_c%0d: got %b expected %b", c, rif.req_ready, exp_rdy);
      end
      if (c == 1) begin
        n_tests++;
        if (mem_en_b !== 1'b1 || mem_addr_b !== 23'h203 || mem_addr_a !== 23'h1005) begin
          n_fail++; $display("FAIL ns_cmd_b: en_b %b addr_b %h addr_a %h expected 1 203 1005",
                             mem_en_b, mem_addr_b, mem_addr_a);
        end
      end
      if (c == 3) begin
        n_tests++;
        if (rif.rsp_valid !== 4'b1001 || rsp_of(3) !== rr_data(3)) begin
          n_fail++; $display("FAIL ns_rsp: rsp_valid %b data3 %h expected 1001 %h",
                             rif.rsp_valid, rsp_of(3), rr_data(3));
        end
      end
      step();
    end
    clear_reqs();
    step();
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_reqs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_hazard();
    test_byte_enable();
    test_reset_midflight();
    test_no_starve();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
